// File: rtl/myproject_product_accumulator.sv
// -----------------------------------------------------------------------------
// myproject_product_accumulator
//
// Sums N_TERMS signed 28-bit products into a wide accumulator. On the last
// term of a group it adds the bias (aligned to the fixed-point position),
// rounds half up, shifts out SHIFT fractional bits and saturates the result
// to signed 16 bits. The result is then held until downstream takes it.
//
// Configuration macro:
//   PRODUCT_ACC_RELU_EN  - when defined, negative rounded results become 0
//                          (out_sat stays 0 for those outputs).
//
// Ports:
//   ap_clk       in   clock, all state changes on the rising edge
//   ap_rst       in   synchronous active-high reset
//   prod_data    in   [27:0] signed product term
//   prod_valid   in   prod_data is valid
//   prod_ready   out  block accepts prod_data this cycle (state ACC)
//   bias         in   [15:0] signed bias in output format, taken with last term
//   out_data     out  [15:0] signed saturated result
//   out_sat      out  out_data was clipped
//   out_valid    out  out_data/out_sat valid (state HOLD)
//   out_ready    in   downstream accepts the output
//   dbg_state_o  out  current FSM state (0 = ACC, 1 = HOLD)
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1; valid never depends combinationally on ready, and the data on a
// valid channel stays stable until it is accepted.
// -----------------------------------------------------------------------------
module myproject_product_accumulator #(
    parameter int N_TERMS   = 9,
    parameter int SHIFT     = 10,
    parameter int ACC_WIDTH = 32
) (
    input  logic        ap_clk,
    input  logic        ap_rst,
    input  logic [27:0] prod_data,
    input  logic        prod_valid,
    output logic        prod_ready,
    input  logic [15:0] bias,
    output logic [15:0] out_data,
    output logic        out_sat,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        dbg_state_o
);

    localparam int CNT_W = $clog2(N_TERMS + 1);
    // Room for the accumulator plus the shifted 16-bit bias and rounding term.
    localparam int SUM_W = ACC_WIDTH + 18;

    localparam logic signed [SUM_W-1:0] ROUND_C = SUM_W'(2 ** (SHIFT - 1));
    localparam logic signed [SUM_W-1:0] MAX_V   = SUM_W'(32767);
    localparam logic signed [SUM_W-1:0] MIN_V   = -SUM_W'(32768);

    typedef enum logic {
        ST_ACC  = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

    state_e                        state_q, state_d;
    logic signed [ACC_WIDTH-1:0]   acc_q, acc_d;
    logic        [CNT_W-1:0]       cnt_q, cnt_d;
    logic        [15:0]            out_data_q, out_data_d;
    logic                          out_sat_q, out_sat_d;

    logic                          accept;
    logic                          last_term;
    logic signed [SUM_W-1:0]       sum_full;
    logic signed [SUM_W-1:0]       shifted;
    logic signed [SUM_W-1:0]       rnd_val;
    logic                          sat_hi;
    logic                          sat_lo;

    // Final sum for the closing term of a group; only used when last_term.
    assign sum_full = SUM_W'(acc_q)
                    + SUM_W'($signed(prod_data))
                    + (SUM_W'($signed(bias)) <<< SHIFT)
                    + ROUND_C;
    assign shifted  = sum_full >>> SHIFT;

`ifdef PRODUCT_ACC_RELU_EN
    assign rnd_val = shifted[SUM_W-1] ? '0 : shifted;
`else
    assign rnd_val = shifted;
`endif

    assign sat_hi = rnd_val > MAX_V;
    assign sat_lo = rnd_val < MIN_V;

    assign prod_ready  = (state_q == ST_ACC);
    assign out_valid   = (state_q == ST_HOLD);
    assign out_data    = out_data_q;
    assign out_sat     = out_sat_q;
    assign dbg_state_o = state_q;

    assign accept    = prod_valid && prod_ready;
    assign last_term = (cnt_q == CNT_W'(N_TERMS - 1));

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        out_data_d = out_data_q;
        out_sat_d  = out_sat_q;
        case (state_q)
            ST_ACC: begin
                if (accept) begin
                    if (last_term) begin
                        out_data_d = sat_hi ? 16'h7FFF :
                                     sat_lo ? 16'h8000 : rnd_val[15:0];
                        out_sat_d  = sat_hi || sat_lo;
                        acc_d      = '0;
                        cnt_d      = '0;
                        state_d    = ST_HOLD;
                    end else begin
                        acc_d = acc_q + ACC_WIDTH'($signed(prod_data));
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    state_d = ST_ACC;
                end
            end
            default: state_d = ST_ACC;
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q    <= ST_ACC;
            acc_q      <= '0;
            cnt_q      <= '0;
            out_data_q <= '0;
            out_sat_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            out_data_q <= out_data_d;
            out_sat_q  <= out_sat_d;
        end
    end

endmodule

// File: tb/tb_myproject_product_accumulator.sv
// -----------------------------------------------------------------------------
// Bench for myproject_product_accumulator (N_TERMS=9, SHIFT=10, ACC_WIDTH=32).
// Expected {sat,data} pairs are computed from the driven terms and queued when
// the closing term of a group is accepted; the monitor pops them on each
// output handshake.
// -----------------------------------------------------------------------------
module tb_myproject_product_accumulator;

    logic        clk = 1'b0;
    logic        ap_rst;
    logic [27:0] prod_data;
    logic        prod_valid;
    logic        prod_ready;
    logic [15:0] bias;
    logic [15:0] out_data;
    logic        out_sat;
    logic        out_valid;
    logic        out_ready;
    logic        dbg_state;

    logic        ready_man;
    logic        ready_rnd = 1'b1;
    logic        rnd_mode;

    assign out_ready = rnd_mode ? ready_rnd : ready_man;

    myproject_product_accumulator #(
        .N_TERMS   (9),
        .SHIFT     (10),
        .ACC_WIDTH (32)
    ) dut (
        .ap_clk      (clk),
        .ap_rst      (ap_rst),
        .prod_data   (prod_data),
        .prod_valid  (prod_valid),
        .prod_ready  (prod_ready),
        .bias        (bias),
        .out_data    (out_data),
        .out_sat     (out_sat),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .dbg_state_o (dbg_state)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) ready_rnd <= ($urandom_range(0, 3) != 0);

    // ---------------- scoreboard state ----------------
    logic [16:0] exp_q[$];
    logic [16:0] e;
    int          n_checks = 0;
    int          n_pass   = 0;
    longint      m_acc;
    int          m_cnt;
    int          last_acc_cyc;
    logic        prev_ov = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    function automatic logic [16:0] model_out(input longint total);
        longint r;
        r = (total + 512) >>> 10;
`ifdef PRODUCT_ACC_RELU_EN
        if (r < 0) r = 0;
`endif
        if (r > 32767)  return {1'b1, 16'h7FFF};
        if (r < -32768) return {1'b1, 16'h8000};
        return {1'b0, r[15:0]};
    endfunction

    // ---------------- driver tasks (called at posedge+#1) ----------------
    task automatic idle(input int n);
        prod_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input int p, input int b);
        int guard;
        guard      = 0;
        prod_data  = p[27:0];
        bias       = b[15:0];
        prod_valid = 1'b1;
        @(negedge clk);
        while (!prod_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!prod_ready) begin
            check_eq("accept_timeout", 32'd0, 32'd1);
            prod_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        prod_valid   = 1'b0;
        last_acc_cyc = cyc;
        m_acc        = m_acc + longint'(p);
        m_cnt++;
        if (m_cnt == 9) begin
            exp_q.push_back(model_out(m_acc + longint'(b) * 1024));
            m_acc = 0;
            m_cnt = 0;
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (out_valid && !prev_ov && !ap_rst)
            check_eq("valid_latency", cyc - last_acc_cyc, 32'd0);
        if (out_valid && out_ready && !ap_rst) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_out", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check_eq("out_data", {16'd0, out_data}, {16'd0, e[15:0]});
                check_eq("out_sat", {31'd0, out_sat}, {31'd0, e[16]});
            end
        end
        prev_ov = out_valid;
    end

    // ---------------- main sequence ----------------
    initial begin
        int p;
        int b;
        int guard;
        ap_rst       = 1'b1;
        prod_valid   = 1'b0;
        prod_data    = '0;
        bias         = '0;
        ready_man    = 1'b1;
        rnd_mode     = 1'b0;
        m_acc        = 0;
        m_cnt        = 0;
        last_acc_cyc = 0;
        repeat (3) @(posedge clk);
        #1;
        ap_rst = 1'b0;

        @(negedge clk);
        check_eq("rst_prod_ready", {31'd0, prod_ready}, 32'd1);
        check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_eq("rst_out_data", {16'd0, out_data}, 32'd0);
        check_eq("rst_out_sat", {31'd0, out_sat}, 32'd0);
        check_eq("rst_state", {31'd0, dbg_state}, 32'd0);
        @(posedge clk);
        #1;

        // Directed groups
        repeat (9) send(1024, 0);
        idle(2);
        repeat (8) send(0, 0);
        send(512, 0);
        repeat (8) send(0, 0);
        send(-512, 0);
        repeat (9) send(134217727, 0);
        repeat (9) send(-134217728, 0);
        repeat (9) send(-1024, 0);
        repeat (9) send(1024, 20);
        repeat (9) send(1024, -20);

        // Output stall: HOLD must keep its data and block input
        idle(2);
        ready_man = 1'b0;
        repeat (9) send(1024, 0);
        repeat (5) begin
            @(negedge clk);
            check_eq("stall_prod_ready", {31'd0, prod_ready}, 32'd0);
            check_eq("stall_out_valid", {31'd0, out_valid}, 32'd1);
            check_eq("stall_out_data", {16'd0, out_data}, 32'd9);
            check_eq("stall_state", {31'd0, dbg_state}, 32'd1);
        end
        @(posedge clk);
        #1;
        ready_man = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_eq("release_out_valid", {31'd0, out_valid}, 32'd0);
        check_eq("release_prod_ready", {31'd0, prod_ready}, 32'd1);
        @(posedge clk);
        #1;

        // Reset mid-group discards the partial sum
        repeat (4) send(1024, 0);
        ap_rst = 1'b1;
        @(posedge clk);
        #1;
        ap_rst = 1'b0;
        m_acc  = 0;
        m_cnt  = 0;
        repeat (9) send(1024, 0);
        idle(2);

        // Reset in HOLD discards the pending output
        ready_man = 1'b0;
        repeat (9) send(1024, 3);
        ap_rst = 1'b1;
        @(posedge clk);
        #1;
        ap_rst = 1'b0;
        ready_man = 1'b1;
        if (exp_q.size() > 0) void'(exp_q.pop_back());
        @(negedge clk);
        check_eq("hold_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_eq("hold_rst_out_data", {16'd0, out_data}, 32'd0);
        check_eq("hold_rst_prod_ready", {31'd0, prod_ready}, 32'd1);
        @(posedge clk);
        #1;

        // Random groups with gaps and downstream back-pressure
        rnd_mode = 1'b1;
        for (int g = 0; g < 20; g++) begin
            for (int t = 0; t < 9; t++) begin
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
                if (g % 2 == 0) begin
                    p = int'($urandom_range(0, 2097151)) - 1048576;
                    b = int'($urandom_range(0, 400)) - 200;
                end else begin
                    p = int'($urandom_range(0, 268435455)) - 134217728;
                    b = int'($urandom_range(0, 65535)) - 32768;
                end
                send(p, b);
            end
        end

        // Drain
        guard = 0;
        while (exp_q.size() != 0 && guard < 50) begin
            @(posedge clk);
            guard++;
        end
        rnd_mode = 1'b0;
        #1;
        check_eq("drain", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
